// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the single-port SRAM arbiter:
// FSM state and access-owner encodings plus the default access latency.
package mem_port_arbiter_pkg;

    localparam int DEFAULT_WAIT_CYCLES = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_MEM = 2'd1,
        BUSY_IF  = 2'd2,
        RESP     = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_access_timer.sv
// Loadable down-counter that measures the fixed SRAM access latency;
// done_o flags the last access cycle.
module mem_port_arbiter_access_timer #(
    parameter int WAIT_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);
    localparam int CNT_W = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VAL;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetches and data loads/stores onto one fixed-latency
// SRAM port; data accesses always win, and a flushed fetch completes silently.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_freeze,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              mem_freeze,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              cancel_q, cancel_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic timer_load, timer_dec, timer_done;
    logic busy;

    mem_port_arbiter_access_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load_i(timer_load),
        .dec_i (timer_dec),
        .done_o(timer_done)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        cancel_d    = cancel_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_rd_en || mem_wr_en) begin
                    // A simultaneous read+write is treated as a plain write.
                    state_d    = BUSY_MEM;
                    owner_d    = OWN_MEM;
                    addr_d     = mem_addr;
                    wdata_d    = mem_wr_en ? mem_wdata : '0;
                    we_d       = mem_wr_en;
                    cancel_d   = 1'b0;
                    timer_load = 1'b1;
                end else if (if_req && !if_flush) begin
                    state_d    = BUSY_IF;
                    owner_d    = OWN_IF;
                    addr_d     = if_addr;
                    wdata_d    = '0;
                    we_d       = 1'b0;
                    cancel_d   = 1'b0;
                    timer_load = 1'b1;
                end
            end
            BUSY_MEM, BUSY_IF: begin
                if ((state_q == BUSY_IF) && if_flush) begin
                    cancel_d = 1'b1;
                end
                if (timer_done) begin
                    state_d = RESP;
                    if ((state_q == BUSY_MEM) && !we_q) begin
                        mem_rdata_d = sram_rdata;
                    end
                    // A flush landing in the final cycle must also block the update.
                    if ((state_q == BUSY_IF) && !(cancel_q || if_flush)) begin
                        if_rdata_d = sram_rdata;
                    end
                end else begin
                    timer_dec = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cancel_q    <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            cancel_q    <= cancel_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign busy       = (state_q == BUSY_MEM) || (state_q == BUSY_IF);
    assign sram_en    = busy;
    assign sram_we    = busy && we_q;
    assign sram_addr  = busy ? addr_q  : '0;
    assign sram_wdata = busy ? wdata_q : '0;

    assign if_ready   = (state_q == RESP) && (owner_q == OWN_IF) && !cancel_q;
    assign mem_ready  = (state_q == RESP) && (owner_q == OWN_MEM);
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;

    assign if_freeze  = if_req && !if_ready && !if_flush;
    assign mem_freeze = (mem_rd_en || mem_wr_en) && !mem_ready;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for a single-port, fixed-latency SRAM shared by instruction fetch and the MEM stage. It accepts fetch reads and data loads/stores, serialises them onto one SRAM port and returns per-requester ready pulses. Each requester's freeze signal holds its pipeline stage until its access completes.

## Interface
- WAIT_CYCLES, 3: SRAM access cycles per transaction, ≥1
- ADDR_W, 32: address width
- DATA_W, 32: data width

Ports:
- clk  in  1  single clock; rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch read request; held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  branch taken; cancels a pending or in-flight fetch response
- if_rdata  out  DATA_W  fetched instruction; valid while if_ready
- if_ready  out  1  one-cycle fetch completion pulse
- if_freeze  out  1  = if_req & ~if_ready & ~if_flush
- mem_rd_en  in  1  load request; held until mem_ready
- mem_wr_en  in  1  store request; held until mem_ready
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data; valid while mem_ready
- mem_ready  out  1  one-cycle data completion pulse
- mem_freeze  out  1  = (mem_rd_en | mem_wr_en) & ~mem_ready
- sram_en  out  1  SRAM access active
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data; valid in the last access cycle

## Operation
- FSM states: IDLE, BUSY_MEM, BUSY_IF, RESP.
- IDLE:
  - (mem_rd_en | mem_wr_en) → BUSY_MEM. Latch addr, wdata and we = mem_wr_en. Load the counter with WAIT_CYCLES-1.
  - else if_req & ~if_flush → BUSY_IF. Latch if_addr, we = 0. Load the counter.
  - else stay in IDLE.
- Priority: MEM over IF, always. The MEM instruction is older, and a MEM stall freezes IF anyway.
- mem_rd_en & mem_wr_en together: the write is performed and the read is ignored.
- BUSY_*:
  - sram_en = 1; sram_addr, sram_wdata and sram_we come from the latched registers.
  - The counter decrements each cycle.
  - At counter == 0: capture sram_rdata into the owner's rdata register (reads only), then → RESP.
- RESP: assert the owner's ready for exactly one cycle, then → IDLE. sram_en = 0.
- Stores: mem_rdata keeps its previous value; mem_ready still pulses.
- if_flush:
  - Asserted in any cycle of BUSY_IF: the SRAM access runs to completion and is not aborted. The response is marked cancelled, if_ready is suppressed in RESP, and if_rdata is not updated.
  - Asserted in IDLE: if_req is ignored that cycle.
  - No effect on MEM accesses.
- Requests are sampled only in IDLE. Request changes during BUSY/RESP are ignored, except if_flush.
- Outputs in IDLE and RESP: sram_en = 0, sram_we = 0, sram_addr = 0, sram_wdata = 0.

## Timing
- Request sampled in IDLE at cycle 0 → BUSY for cycles 1..WAIT_CYCLES → ready pulse in cycle WAIT_CYCLES+1.
- Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
- The requester advances on the edge that ends RESP. Its next request is sampled in the following IDLE cycle.
- Reset values: state IDLE, counter 0, cancel flag 0, latched regs 0, if_rdata 0, mem_rdata 0, if_ready 0, mem_ready 0, all sram_* outputs 0.
- Reset mid-access: rst wins over all transitions. The next cycle is IDLE with no ready pulse, and the in-flight access is dropped.
- Combinational paths: freezes from inputs and ready; sram_* from state and latched regs.

## Structure
- Shared package:
  - state enum (IDLE, BUSY_MEM, BUSY_IF, RESP)
  - owner encoding (OWN_IF, OWN_MEM)
  - default WAIT_CYCLES constant
- Sub-module access_timer: loadable down-counter, width clog2(WAIT_CYCLES)+1, with load, decrement and done (== 0) outputs.
- Top level contains the FSM, latch registers, cancel flag and output muxing.

## Test plan
- Fetch only, WAIT_CYCLES=3, if_addr=0x10, SRAM returns 0xE3A01005 → sram_en high in cycles 1–3, if_ready plus if_rdata=0xE3A01005 in cycle 4, if_freeze high in cycles 0–3.
- Simultaneous if_req and mem_rd_en, mem_addr=0x400 returning 0xAB → MEM served first (mem_ready in cycle 4), fetch served next (if_ready in cycle 9).
- Store mem_addr=0x8, mem_wdata=0x55 → sram_we=1 and sram_wdata=0x55 in cycles 1–3, mem_ready in cycle 4, mem_rdata unchanged.
- if_flush pulsed in cycle 2 of a fetch → access completes, no if_ready, if_rdata unchanged, state IDLE in cycle 5.
- rst asserted in cycle 2 of a MEM read → all outputs 0 from the next cycle, no mem_ready ever issued. A new fetch afterwards completes normally.
- Both mem_rd_en and mem_wr_en high → only a write (sram_we=1) is issued, followed by one mem_ready pulse.
